// File: rtl/vita_pkt_gen_mc.sv
// Multi-channel VITA-style fifo36 test packet source: round-robin over masked channels,
// per-channel sequence numbers, selectable payload patterns, inter-packet gap and packet limit.
module vita_pkt_gen_mc #(
  parameter int NUM_CHAN = 4,
  parameter int LEN_W    = 16,
  parameter int GAP_W    = 8,
  parameter int SEQ_W    = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                enable,
  input  logic [LEN_W-1:0]    len,
  input  logic [GAP_W-1:0]    gap,
  input  logic [31:0]         num_pkts,
  input  logic [1:0]          mode,
  input  logic [NUM_CHAN-1:0] chan_mask,
  output logic [35:0]         data_o,
  output logic                src_rdy_o,
  input  logic                dst_rdy_i,
  output logic                done,
  output logic [31:0]         pkt_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_PAYLOAD, S_GAP, S_DONE} state_t;

  state_t             r_state;
  logic [3:0]         r_chan;
  logic [15:0]        r_len;
  logic [15:0]        r_k;
  logic [1:0]         r_mode;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [30:0]        r_lfsr;
  logic [SEQ_W-1:0]   r_seq [NUM_CHAN];
  logic [31:0]        r_pkt_cnt;
  logic               r_done;
  logic               r_src_rdy;
  logic [35:0]        r_data;

  logic               w_fire, w_eof_fire, w_can_start, w_hit_done, w_start;
  logic [31:0]        w_cnt_inc, w_mask_ext;
  logic [15:0]        w_len_eff, w_k_nxt;
  logic [30:0]        w_lfsr_nxt, w_pay_lfsr;
  logic [4:0]         w_cand;
  logic [3:0]         w_next_chan;
  logic [SEQ_W-1:0]   w_cur_seq, w_nxt_seq, w_start_seq;
  logic [35:0]        w_hdr0, w_hdr1, w_pay;

  function automatic logic [31:0] f_payload(input logic [15:0] k, input logic [1:0] m,
                                            input logic [30:0] l);
    case (m)
      2'd0:    return {~k, k};
      2'd1:    return {16'd0, k};
      2'd2:    return {1'b0, l};
      default: return 32'hA5A55A5A;
    endcase
  endfunction

  assign data_o    = r_data;
  assign src_rdy_o = r_src_rdy;
  assign done      = r_done;
  assign pkt_cnt   = r_pkt_cnt;

  assign w_fire      = r_src_rdy & dst_rdy_i;
  assign w_eof_fire  = w_fire & r_data[33];
  assign w_can_start = enable & (|chan_mask);
  assign w_cnt_inc   = (&r_pkt_cnt) ? r_pkt_cnt : r_pkt_cnt + 32'd1;
  assign w_hit_done  = (num_pkts != 32'd0) && (w_cnt_inc == num_pkts);
  // Packet start: from IDLE, at the last gap cycle, or back-to-back on a consumed eof.
  assign w_start     = w_can_start &&
                       ((r_state == S_IDLE) ||
                        (r_state == S_GAP && r_gap_cnt == GAP_W'(1)) ||
                        (w_eof_fire && !w_hit_done && r_gap == '0));

  assign w_len_eff  = (len < LEN_W'(2)) ? 16'd2 : 16'(len);
  assign w_mask_ext = 32'(chan_mask);
  assign w_k_nxt    = r_k + 16'd1;
  assign w_lfsr_nxt = {r_lfsr[29:0], r_lfsr[30] ^ r_lfsr[27]};
  assign w_pay_lfsr = (r_state == S_PAYLOAD) ? w_lfsr_nxt : r_lfsr;

  // Nearest set mask bit after the previous channel; lowest distance wins.
  always_comb begin
    w_cand      = '0;
    w_next_chan = r_chan;
    for (int i = NUM_CHAN; i >= 1; i--) begin
      w_cand = 5'(r_chan) + 5'(i);
      if (w_cand >= 5'(NUM_CHAN)) w_cand = w_cand - 5'(NUM_CHAN);
      if (w_mask_ext[w_cand]) w_next_chan = w_cand[3:0];
    end
  end

  always_comb begin
    w_cur_seq = '0;
    w_nxt_seq = '0;
    for (int j = 0; j < NUM_CHAN; j++) begin
      if (r_chan == 4'(j))      w_cur_seq = r_seq[j];
      if (w_next_chan == 4'(j)) w_nxt_seq = r_seq[j];
    end
  end

  // A back-to-back restart on the same channel must see the seq bumped by this eof.
  assign w_start_seq = (w_eof_fire && w_next_chan == r_chan) ? w_cur_seq + SEQ_W'(1) : w_nxt_seq;

  assign w_hdr0 = {2'b00, 1'b0, 1'b1, w_next_chan, 12'(w_start_seq), w_len_eff};
  assign w_hdr1 = {2'b00, (r_len == 16'd2), 1'b0, 32'(w_cur_seq)};
  assign w_pay  = {2'b00, (w_k_nxt == r_len - 16'd1), 1'b0, f_payload(w_k_nxt, r_mode, w_pay_lfsr)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_chan    <= 4'(NUM_CHAN - 1);
      r_len     <= 16'd2;
      r_k       <= '0;
      r_mode    <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_lfsr    <= '1;
      r_pkt_cnt <= '0;
      r_done    <= 1'b0;
      r_src_rdy <= 1'b0;
      r_data    <= '0;
      for (int j = 0; j < NUM_CHAN; j++) r_seq[j] <= '0;
    end else if (clear) begin
      r_state   <= S_IDLE;
      r_chan    <= 4'(NUM_CHAN - 1);
      r_len     <= 16'd2;
      r_k       <= '0;
      r_mode    <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_lfsr    <= '1;
      r_pkt_cnt <= '0;
      r_done    <= 1'b0;
      r_src_rdy <= 1'b0;
      r_data    <= '0;
      for (int j = 0; j < NUM_CHAN; j++) r_seq[j] <= '0;
    end else begin
      if (w_eof_fire) begin
        for (int j = 0; j < NUM_CHAN; j++)
          if (r_chan == 4'(j)) r_seq[j] <= r_seq[j] + SEQ_W'(1);
        r_pkt_cnt <= w_cnt_inc;
      end
      if (r_state == S_PAYLOAD && w_fire) r_lfsr <= w_lfsr_nxt;

      if (w_start) begin
        r_state   <= S_HDR0;
        r_chan    <= w_next_chan;
        r_len     <= w_len_eff;
        r_mode    <= mode;
        r_gap     <= gap;
        r_k       <= '0;
        r_lfsr    <= '1;
        r_src_rdy <= 1'b1;
        r_data    <= w_hdr0;
      end else begin
        case (r_state)
          S_HDR0: if (w_fire) begin
            r_state <= S_HDR1;
            r_k     <= 16'd1;
            r_data  <= w_hdr1;
          end
          S_HDR1, S_PAYLOAD: if (w_fire) begin
            if (r_data[33]) begin
              r_src_rdy <= 1'b0;
              r_data    <= '0;
              if (w_hit_done) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else if (r_gap != '0) begin
                r_state   <= S_GAP;
                r_gap_cnt <= r_gap;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_state <= S_PAYLOAD;
              r_k     <= w_k_nxt;
              r_data  <= w_pay;
            end
          end
          S_GAP: begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            if (r_gap_cnt == GAP_W'(1)) r_state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/vita_pkt_gen_mc.md
Name: vita_pkt_gen_mc

Overview:
Multi-channel, parametrised VITA-style test packet source for fifo36 streams, used for link and throughput bring-up.
Round-robins packets across a masked set of channels and keeps a per-channel sequence number.
Supports selectable payload patterns, a programmable inter-packet gap, and a bounded packet count with a done flag.
Drives the standard fifo36 interface: {2'b00, eof, sof, data[31:0]} with src_rdy/dst_rdy.

Parameters:
NUM_CHAN, 4, number of channels; legal range 1..16.
LEN_W, 16, width of len input; legal range 2..16.
GAP_W, 8, width of gap input.
SEQ_W, 12, per-channel sequence counter width; legal range 4..32.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous clear; same effect as reset
enable  input  1  run control
len  input  LEN_W  packet length in 32-bit words, header included
gap  input  GAP_W  idle cycles inserted after each packet
num_pkts  input  32  total packets to send; 0 = unlimited
mode  input  2  payload pattern select
chan_mask  input  NUM_CHAN  channels eligible for packets
data_o  output  36  {2'b00, eof, sof, data}
src_rdy_o  output  1  word valid
dst_rdy_i  input  1  sink ready
done  output  1  num_pkts reached
pkt_cnt  output  32  packets completed since clear

Behaviour:
- Reset/clear values: state IDLE, src_rdy_o=0, data_o=0, done=0, pkt_cnt=0, all seq counters 0, current channel = NUM_CHAN-1 (so channel 0 is picked first).
- Consume: a word is consumed when src_rdy_o & dst_rdy_i.
- Output stability: while src_rdy_o=1 and dst_rdy_i=0, data_o holds stable. data_o=0 whenever src_rdy_o=0.
- FSM states: IDLE, HDR0, HDR1, PAYLOAD, GAP, DONE.
- IDLE: moves to HDR0 when enable=1 and chan_mask!=0. Otherwise stays.
- Packet-start latch: on the IDLE/GAP->HDR0 transition, the block latches:
  - effective length L = max(len, 2);
  - mode;
  - gap;
  - channel c = next set bit of chan_mask after the previous channel, wrapping modulo NUM_CHAN.
- HDR0: data = {c[3:0], seq[c] zero-extended/truncated to 12 bits, len latched zero-extended to 16 bits}; sof=1.
- HDR1: data = seq[c] zero-extended to 32 bits.
- PAYLOAD: word index k runs 2..L-1. data depends on mode:
  - 0: {~k[15:0], k[15:0]};
  - 1: k zero-extended to 32 bits;
  - 2: {1'b0, lfsr}, where lfsr is a PRBS31 (x^31+x^28+1) reseeded to 31'h7FFFFFFF at HDR0 and advanced on each consumed payload word;
  - 3: constant 32'hA5A55A5A.
- eof: asserted on word L-1. If L=2, eof is on the HDR1 word and there is no PAYLOAD.
- On consumed eof:
  - seq[c] increments, wrapping at 2^SEQ_W;
  - pkt_cnt increments;
  - if num_pkts!=0 and the new pkt_cnt==num_pkts, go to DONE;
  - else if gap!=0, go to GAP;
  - else if enable & chan_mask!=0, go directly to HDR0 (back-to-back, no bubble);
  - else go to IDLE.
- GAP: src_rdy_o=0 for exactly gap cycles, then the same enable/mask check as above.
- DONE: done=1, src_rdy_o=0. Held until clear/reset. enable is ignored.
- enable deasserted mid-packet: the current packet completes fully and is never truncated. enable is checked only at packet boundaries.
- chan_mask changes: take effect at the next packet-start latch. len/mode/gap changes mid-packet are ignored.
- clear mid-packet: immediate return to IDLE. The packet is truncated with no eof; downstream must be cleared as well. clear has priority over every other event.
- pkt_cnt saturates at 32'hFFFFFFFF in unlimited mode.
- Latency: first word valid 1 cycle after enable is sampled high in IDLE. src_rdy_o is registered (no combinational path from dst_rdy_i).

Test Plan:
- Basic packet: NUM_CHAN=4, mask=4'b0001, len=5, mode=0, gap=0, dst_rdy=1, num_pkts=2 → two packets.
  - Packet 1: 32'h00000005 (sof), 32'h00000000, FFFD0002, FFFC0003, FFFB0004 (eof).
  - Packet 2: header 32'h00010005, then seq word 1.
  - Then done=1, pkt_cnt=2.
- Round robin: mask=4'b1010, len=2, num_pkts=4 → channel order 1,3,1,3. Headers 32'h10000002, 32'h30000002, 32'h10010002, 32'h30010002.
- Backpressure: dst_rdy_i toggles randomly, mode=2 → data_o stable during stalls. First payload word 32'h7FFFFFFF. LFSR matches the reference model, with no skipped or repeated words.
- Gap/enable: gap=3 → exactly 3 src_rdy_o=0 cycles between eof and next sof. enable dropped at k=2 of len=8 → packet completes to eof, then IDLE.
- Wrap and edge cases:
  - SEQ_W=4, 17 packets on channel 0 → the 17th header shows seq=0.
  - len=0 or len=1 → 2-word packets.
  - mask=0 → src_rdy_o stays 0.
- Reset/clear mid-packet: assert clear or reset_n low at word 3 → next cycle src_rdy_o=0, pkt_cnt=0. Restart begins with channel 0, seq 0, sof.
